// File: rtl/scale_mul_pkg.sv
// rtl/scale_mul_pkg.sv - shared widths, result type and truncation helper for scale_mul_pipe
// Contents:
//   DEF_A_W/DEF_B_W/DEF_C_W  default operand / doubled / product field widths
//   PROD_W                   full product width for the default widths
//   MAX_W                    widest value the truncation helper handles
//   trunc_res_t              truncated value plus overflow flag
//   trunc_field()            truncate a full-width value to w bits, flag lost bits
package scale_mul_pkg;

    localparam int DEF_A_W = 3;
    localparam int DEF_B_W = 6;
    localparam int DEF_C_W = 6;
    localparam int PROD_W  = DEF_B_W + DEF_A_W;
    localparam int MAX_W   = (PROD_W > 32) ? PROD_W : 32;

    typedef struct packed {
        logic             ovf;
        logic [MAX_W-1:0] val;
    } trunc_res_t;

    // Unsigned truncation: val keeps the low w bits, ovf is set when any
    // higher bit was non-zero, i.e. full >= 2**w.
    function automatic trunc_res_t trunc_field(input logic [MAX_W-1:0] full, input int w);
        trunc_res_t       r;
        logic [MAX_W-1:0] mask;
        mask  = (MAX_W'(1) << w) - MAX_W'(1);
        r.val = full & mask;
        r.ovf = |(full & ~mask);
        return r;
    endfunction

endpackage

// File: rtl/pipe_reg_slice.sv
// rtl/pipe_reg_slice.sv - single-entry valid/ready register slice
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   up_valid_i      upstream data valid
//   up_ready_o      slice can load this cycle (empty, or draining downstream)
//   up_data_i       upstream data
//   dn_valid_o      slice holds valid data
//   dn_ready_i      downstream accepts the held data
//   dn_data_o       held data
module pipe_reg_slice
    import scale_mul_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid_i,
    output logic          up_ready_o,
    input  logic [DW-1:0] up_data_i,
    output logic          dn_valid_o,
    input  logic          dn_ready_i,
    output logic [DW-1:0] dn_data_o
);

    logic          valid_q;
    logic [DW-1:0] data_q;
    logic          load_en;

    // Loads when empty or when the current entry leaves this same cycle.
    assign load_en    = !valid_q || dn_ready_i;
    assign up_ready_o = load_en;
    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_en) begin
            valid_q <= up_valid_i;
            // Data only moves with a real beat so idle cycles leave it untouched.
            if (up_valid_i) begin
                data_q <= up_data_i;
            end
        end
    end

endmodule

// File: rtl/scale_mul_pipe.sv
// rtl/scale_mul_pipe.sv - two-stage b = 2*a, c = b*a pipeline with valid/ready on both sides
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   in_valid     upstream operand valid
//   in_ready     operand accepted this cycle (combinational from out_ready)
//   in_a         operand a
//   out_valid    result valid
//   out_ready    downstream accepts result
//   out_b        2*a truncated to B_W
//   out_c        b*a truncated to C_W
//   out_ovf      2*a or b*a lost bits to truncation
//   busy         either stage occupied
module scale_mul_pipe
    import scale_mul_pkg::*;
#(
    parameter int A_W = DEF_A_W,
    parameter int B_W = DEF_B_W,
    parameter int C_W = DEF_C_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] in_a,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [B_W-1:0] out_b,
    output logic [C_W-1:0] out_c,
    output logic           out_ovf,
    output logic           busy
);

    localparam int FULL_W = B_W + A_W;
    localparam int S1_W   = 1 + B_W + A_W;
    localparam int S2_W   = 1 + B_W + C_W;

    // Stage 1 input: {ovf1, b1, a1}
    logic [A_W:0]      dbl_a;
    trunc_res_t        s1_res;
    logic [S1_W-1:0]   s1_data_d;

    // Stage 1 output / stage 2 input
    logic              v1;
    logic              s2_en;
    logic [S1_W-1:0]   s1_data_q;
    logic              ovf1;
    logic [B_W-1:0]    b1;
    logic [A_W-1:0]    a1;
    logic [FULL_W-1:0] prod;
    trunc_res_t        s2_res;
    logic [S2_W-1:0]   s2_data_d;

    // Stage 2 output: {out_ovf, out_b, out_c}
    logic [S2_W-1:0]   s2_data_q;

    logic              unused_hi;

    assign dbl_a     = {in_a, 1'b0};
    assign s1_res    = trunc_field(MAX_W'(dbl_a), B_W);
    assign s1_data_d = {s1_res.ovf, s1_res.val[B_W-1:0], in_a};

    pipe_reg_slice #(.DW(S1_W)) u_s1 (
        .clk        (clk),
        .rst        (rst),
        .up_valid_i (in_valid),
        .up_ready_o (in_ready),
        .up_data_i  (s1_data_d),
        .dn_valid_o (v1),
        .dn_ready_i (s2_en),
        .dn_data_o  (s1_data_q)
    );

    assign {ovf1, b1, a1} = s1_data_q;

    // Product at full width so the overflow test sees every bit.
    assign prod      = FULL_W'(b1) * FULL_W'(a1);
    assign s2_res    = trunc_field(MAX_W'(prod), C_W);
    assign s2_data_d = {ovf1 | s2_res.ovf, b1, s2_res.val[C_W-1:0]};

    pipe_reg_slice #(.DW(S2_W)) u_s2 (
        .clk        (clk),
        .rst        (rst),
        .up_valid_i (v1),
        .up_ready_o (s2_en),
        .up_data_i  (s2_data_d),
        .dn_valid_o (out_valid),
        .dn_ready_i (out_ready),
        .dn_data_o  (s2_data_q)
    );

    assign {out_ovf, out_b, out_c} = s2_data_q;
    assign busy = v1 | out_valid;

    // Bits above the field are zero after masking; gathered so dropping them is explicit.
    assign unused_hi = ^{s1_res.val[MAX_W-1:B_W], s2_res.val[MAX_W-1:C_W]};

endmodule

// File: tb/tb_scale_mul_pipe.sv
// tb/tb_scale_mul_pipe.sv - directed self-checking bench for scale_mul_pipe
module tb_scale_mul_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_a;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_b;
    logic [5:0] out_c;
    logic       out_ovf;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;

    scale_mul_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) n_out++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One isolated operand with out_ready high: result visible in cycle 2, gone in cycle 3.
    task automatic single(input logic [2:0] a, input logic [5:0] eb, input logic [5:0] ec,
                          input logic eo);
        @(negedge clk);
        in_valid = 1'b1; in_a = a; out_ready = 1'b1;
        #1 check("single_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("single_lat1_valid", out_valid, 0);
        @(negedge clk);
        check("single_valid", out_valid, 1);
        check("single_b", out_b, eb);
        check("single_c", out_c, ec);
        check("single_ovf", out_ovf, eo);
        @(negedge clk);
        check("single_drained", out_valid, 0);
    endtask

    logic [5:0] stream_c [4] = '{6'd2, 6'd8, 6'd18, 6'd32};

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; out_ready = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_b", out_b, 0);
        check("rst_out_c", out_c, 0);
        check("rst_out_ovf", out_ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        single(3'd3, 6'd6, 6'd18, 1'b0);
        single(3'd7, 6'd14, 6'd34, 1'b1);
        single(3'd5, 6'd10, 6'd50, 1'b0);

        // Streaming 1..4 back to back
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check("stream_valid", out_valid, 1);
                check("stream_c", out_c, stream_c[i-2]);
            end
            if (i < 4) begin
                in_valid = 1'b1; in_a = 3'(i + 1);
                #1 check("stream_in_ready", in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
        end

        // Backpressure: push 3,4,5 with out_ready low
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_a = 3'd3;
        @(negedge clk);
        in_a = 3'd4;
        @(negedge clk);
        in_a = 3'd5;
        #1;
        check("bp_in_ready_full", in_ready, 0);
        check("bp_valid", out_valid, 1);
        check("bp_b", out_b, 6);
        @(negedge clk);
        check("bp_hold_ready", in_ready, 0);
        check("bp_hold_b", out_b, 6);
        check("bp_hold_c", out_c, 18);
        check("bp_hold_ovf", out_ovf, 0);
        @(negedge clk);
        check("bp_rel_c0", out_c, 18);
        out_ready = 1'b1;
        #1 check("bp_drain_accept", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_rel_valid1", out_valid, 1);
        check("bp_rel_b1", out_b, 8);
        check("bp_rel_c1", out_c, 32);
        @(negedge clk);
        check("bp_rel_c2", out_c, 50);
        @(negedge clk);
        check("bp_empty", out_valid, 0);
        check("bp_busy", busy, 0);
        check("result_count", n_out, 10);

        // Mid-operation asynchronous reset with two operands in flight
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_a = 3'd3;
        @(negedge clk);
        in_a = 3'd4;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_out_valid", out_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_out_c", out_c, 0);
        check("mid_in_ready", in_ready, 1);
        #4 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_valid", out_valid, 0);
        single(3'd2, 6'd4, 6'd8, 1'b0);

        single(3'd0, 6'd0, 6'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/scale_mul_pipe.md
Name: scale_mul_pipe

Overview:
- Two-stage registered datapath that takes operand `a` and produces `b = 2*a`, then `c = b*a`, with valid/ready handshakes on both sides.
- Sits directly downstream of the operand-generation stage and feeds the result checker/monitor.
- Replaces ad-hoc nonblocking `b <= 2*a; c <= b*a` sequencing with an explicit, back-pressurable pipeline whose latency is defined.

Parameters:
- A_W, 3, operand `a` width.
- B_W, 6, width of `b`; `2*a` truncated to B_W.
- C_W, 6, width of `c`; `b*a` truncated to C_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents a valid operand.
- in_ready  output  1  block accepts an operand this cycle.
- in_a  input  A_W  operand.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_b  output  B_W  `2*a` for this result.
- out_c  output  C_W  `b*a`, truncated.
- out_ovf  output  1  the untruncated `b*a` (or `2*a`) exceeded its field width.
- busy  output  1  `v1 | v2` (either stage occupied).

Behaviour:
- Reset (asynchronous, active-high): v1 = v2 = 0. out_b, out_c, out_ovf and all stage data registers clear to 0. in_ready = 1 and busy = 0 as soon as rst is asserted.
- Stage 1 (S1) registers:
  - a1 = in_a
  - b1 = (2*in_a) mod 2^B_W
  - ovf1 = (2*in_a ≥ 2^B_W)
  - v1
- Stage 2 (S2) registers:
  - out_b = b1
  - out_c = (b1*a1) mod 2^C_W
  - out_ovf = ovf1 | (b1*a1 ≥ 2^C_W)
  - out_valid = v2
- Product arithmetic: computed at full width (B_W + A_W bits), then truncated. No signed interpretation.
- Advance rules:
  - s2_en = !v2 | out_ready
  - s1_en = !v1 | s2_en
  - in_ready = s1_en (combinational path from out_ready to in_ready is intentional).
- S1 load: on s1_en, v1 ← in_valid; data regs load only when in_valid & s1_en.
- S2 load: on s2_en, v2 ← v1; data regs load only when v1 & s2_en.
- Latency and throughput: with out_ready held high, a result appears exactly 2 cycles after the accepting edge. Throughput is one result per cycle.
- Backpressure:
  - out_ready = 0 with v2 = 1 holds out_b, out_c and out_ovf stable.
  - S1 keeps filling until v1 = 1, then in_ready = 0.
  - Maximum of 2 operands in flight; none dropped or duplicated.
- Simultaneous events:
  - S2 drain and S1 refill in the same cycle are both allowed.
  - A full pipeline with out_ready = 1 accepts a new operand in that same cycle.
- Handshake rules:
  - Upstream must hold in_a stable while in_valid & !in_ready.
  - The block never deasserts out_valid without a handshake.
- Mid-operation reset: all in-flight operands are discarded; outputs return to their reset values immediately. On the first cycle after deassertion, in_ready = 1.
- Boundary values:
  - a = 0 gives b = 0, c = 0, ovf = 0.
  - The maximum `a` under default widths always sets ovf.

Decomposition:
- Shared package `scale_mul_pkg`:
  - default A_W/B_W/C_W constants
  - localparam PROD_W = B_W + A_W
  - a function returning the truncated product plus its overflow bit
- One natural sub-module, `pipe_reg_slice` (valid/ready register slice, parameterized data width):
  - instantiated twice
  - datapath arithmetic stays in the top level between the slices.

Test Plan:
- Single op: in_a = 3, out_ready = 1. out_valid rises 2 cycles later with out_b = 6, out_c = 18, out_ovf = 0.
- Overflow: in_a = 7. Result out_b = 14, out_c = 34 (98 mod 64), out_ovf = 1. Also in_a = 5: out_b = 10, out_c = 50, out_ovf = 0.
- Streaming: in_a = 1,2,3,4 back-to-back, out_ready = 1. Expect out_c = 2,8,18,32 on consecutive cycles starting at cycle 2, with in_ready constantly 1.
- Backpressure:
  - out_ready = 0, push 3,4,5. 3 and 4 are accepted; in_ready = 0 while 5 waits; out_b = 6 is held stable.
  - Release out_ready. Results arrive in order: c = 18, 32, 50.
- Mid-op reset: pulse rst asynchronously (not clock-aligned) with 2 ops in flight. out_valid and busy drop immediately, out_c = 0. After release, in_a = 2 gives c = 8 with no stale results.
- Zero/edge: in_a = 0 gives out_b = 0, out_c = 0, out_ovf = 0. Simultaneous drain and accept on a full pipeline loses nothing (scoreboard count matches).
